// File: rtl/coremem_arb_pkg.sv
// Shared state type and requester indices for the core-memory arbiter.
package coremem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WRITE_ISO = 1'b1
    } state_e;

    localparam int REQ_INSTR = 0;
    localparam int REQ_DATA  = 1;
    localparam int NUM_REQ   = 2;

endpackage

// File: rtl/coremem_arb_pick.sv
// Two-way requester pick. Define COREMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise data (index 1) always beats instruction fetch (index 0).
module coremem_arb_pick
    import coremem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    input  logic               granted,
    output logic               req_any,
    output logic               winner
);

    assign req_any = |req;

`ifdef COREMEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Reset to data so that the very first tie goes to instruction fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= granted;
        end
    end

    always_comb begin
        winner = req[REQ_DATA];
        if (&req) begin
            winner = ~last_q;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = ^{clk, rst_n, update, granted};
    assign winner      = req[REQ_DATA];
`endif

endmodule

// File: rtl/coremem_arbiter.sv
// Shares one single-port 1-cycle-latency SRAM between instruction fetch (0) and data (1).
// Optional round-robin tie-breaking via COREMEM_ARB_ROUND_ROBIN_EN (fixed data priority otherwise).
module coremem_arbiter
    import coremem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NUM_REQ-1:0]                      req_i,
    input  logic [NUM_REQ-1:0]                      we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      wdata_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]    be_i,
    output logic [NUM_REQ-1:0]                      gnt_o,
    output logic [NUM_REQ-1:0]                      rvalid_o,
    output logic [DATA_WIDTH-1:0]                   rdata_o,
    output logic                                    mem_ce_o,
    output logic                                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
    output logic [DATA_WIDTH-1:0]                   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]                 mem_be_o,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata_i
);

    // state     | meaning
    // IDLE      | pick a winner; reads are granted and strobed at once
    // WRITE_ISO | one isolation cycle is over; grant and strobe the latched write owner

    localparam logic [0:0] S_IDLE      = IDLE;
    localparam logic [0:0] S_WRITE_ISO = WRITE_ISO;

    logic [0:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               resp_q, resp_d;
    logic               resp_wr_q, resp_wr_d;
    logic               req_any, winner;
    logic               sel;
    logic               ce, we;
    logic [NUM_REQ-1:0] gnt;

    coremem_arb_pick u_pick (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .req     (req_i),
        .update  (|gnt),
        .granted (gnt[REQ_DATA]),
        .req_any (req_any),
        .winner  (winner)
    );

    // Everything is gated by rst_ni so outputs read zero for the whole reset pulse.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        resp_d    = 1'b0;
        resp_wr_d = resp_wr_q;
        gnt       = '0;
        ce        = 1'b0;
        we        = 1'b0;
        sel       = owner_q;
        if (rst_ni) begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        sel     = winner;
                        owner_d = winner;
                        if (we_i[winner]) begin
                            state_d = S_WRITE_ISO;
                        end else begin
                            gnt[winner] = 1'b1;
                            ce          = 1'b1;
                            resp_d      = 1'b1;
                            resp_wr_d   = 1'b0;
                        end
                    end
                end
                S_WRITE_ISO: begin
                    gnt[owner_q] = 1'b1;
                    ce           = 1'b1;
                    we           = 1'b1;
                    resp_d       = 1'b1;
                    resp_wr_d    = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            resp_q    <= 1'b0;
            resp_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            resp_q    <= resp_d;
            resp_wr_q <= resp_wr_d;
        end
    end

    always_comb begin
        rvalid_o          = '0;
        rvalid_o[owner_q] = resp_q;
    end

    assign gnt_o       = gnt;
    assign rdata_o     = (resp_q && !resp_wr_q) ? mem_rdata_i : '0;
    assign mem_ce_o    = ce;
    assign mem_we_o    = we;
    assign mem_addr_o  = ce ? addr_i[sel]     : '0;
    assign mem_wdata_o = we ? wdata_i[owner_q] : '0;
    assign mem_be_o    = we ? be_i[owner_q]    : '0;

endmodule
